// File: rtl/ps2_key_sequencer.sv
// rtl/ps2_key_sequencer.sv - PS/2 scan-code byte sequencer with held-key tracking
module ps2_key_sequencer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  key_code,
  output logic        verify,
  output logic [10:0] held_mask,
  output logic        make_pulse,
  output logic        break_pulse,
  output logic [7:0]  event_code,
  output logic        event_ext,
  output logic        err_pulse
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // One-hot position of a tracked game key in held_mask, zero for untracked codes
  function automatic logic [10:0] track_bit(input logic [7:0] c);
    logic [10:0] b;
    b = '0;
    case (c)
      8'h44:   b[0]  = 1'b1;
      8'h4D:   b[1]  = 1'b1;
      8'h2C:   b[2]  = 1'b1;
      8'h34:   b[3]  = 1'b1;
      8'h25:   b[4]  = 1'b1;
      8'h2B:   b[5]  = 1'b1;
      8'h36:   b[6]  = 1'b1;
      8'h33:   b[7]  = 1'b1;
      8'h29:   b[8]  = 1'b1;
      8'h32:   b[9]  = 1'b1;
      8'h1C:   b[10] = 1'b1;
      default: b = '0;
    endcase
    return b;
  endfunction

  // Keyboard housekeeping bytes (ack, BAT result, echo, resend, errors) seen between keys
  function automatic logic is_filler(input logic [7:0] c);
    return (c == 8'h00) || (c == 8'hAA) || (c == 8'hEE) ||
           (c == 8'hFA) || (c == 8'hFE) || (c == 8'hFF);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          verify_q, verify_d;
  logic [10:0]   held_mask_q, held_mask_d;
  logic          make_pulse_q, make_pulse_d;
  logic          break_pulse_q, break_pulse_d;
  logic [7:0]    event_code_q, event_code_d;
  logic          event_ext_q, event_ext_d;
  logic          err_pulse_q, err_pulse_d;

  logic          do_evt;
  logic          evt_brk;
  logic          evt_ext;
  logic [10:0]   tbit;

  // Next-state: prefix sequencing, timeout abort, and event side effects
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_code_d    = key_code_q;
    verify_d      = verify_q;
    held_mask_d   = held_mask_q;
    event_code_d  = event_code_q;
    event_ext_d   = event_ext_q;
    make_pulse_d  = 1'b0;
    break_pulse_d = 1'b0;
    err_pulse_d   = 1'b0;
    do_evt        = 1'b0;
    evt_brk       = 1'b0;
    evt_ext       = 1'b0;
    tbit          = track_bit(rx_data);

    if (rx_valid) begin
      // A byte always wins over a coincident timeout
      cnt_d = '0;
      if (rx_data == 8'hE0) begin
        if (state_q != S_IDLE) err_pulse_d = 1'b1;
        state_d = S_EXT;
      end else if (rx_data == 8'hF0) begin
        case (state_q)
          S_IDLE:  state_d = S_BRK;
          S_EXT:   state_d = S_EXT_BRK;
          default: begin
            err_pulse_d = 1'b1;
            state_d     = S_BRK;
          end
        endcase
      end else if ((state_q == S_IDLE) && is_filler(rx_data)) begin
        state_d = S_IDLE;
      end else begin
        do_evt  = 1'b1;
        evt_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);
        evt_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        state_d = S_IDLE;
      end
    end else if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Stalled prefix: drop it without producing an event
      state_d     = S_IDLE;
      err_pulse_d = 1'b1;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (do_evt) begin
      event_code_d  = rx_data;
      event_ext_d   = evt_ext;
      make_pulse_d  = !evt_brk;
      break_pulse_d = evt_brk;
      // Extended keys are reported but never enter the game-key tracking
      if (!evt_ext) begin
        if (!evt_brk) begin
          key_code_d  = rx_data;
          verify_d    = 1'b1;
          held_mask_d = held_mask_q | tbit;
        end else begin
          held_mask_d = held_mask_q & ~tbit;
          if (rx_data == key_code_q) verify_d = 1'b0;
        end
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      key_code_q    <= 8'h00;
      verify_q      <= 1'b0;
      held_mask_q   <= '0;
      make_pulse_q  <= 1'b0;
      break_pulse_q <= 1'b0;
      event_code_q  <= 8'h00;
      event_ext_q   <= 1'b0;
      err_pulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      verify_q      <= verify_d;
      held_mask_q   <= held_mask_d;
      make_pulse_q  <= make_pulse_d;
      break_pulse_q <= break_pulse_d;
      event_code_q  <= event_code_d;
      event_ext_q   <= event_ext_d;
      err_pulse_q   <= err_pulse_d;
    end
  end

  assign key_code    = key_code_q;
  assign verify      = verify_q;
  assign held_mask   = held_mask_q;
  assign make_pulse  = make_pulse_q;
  assign break_pulse = break_pulse_q;
  assign event_code  = event_code_q;
  assign event_ext   = event_ext_q;
  assign err_pulse   = err_pulse_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb/tb_ps2_key_sequencer.sv - self-checking bench for ps2_key_sequencer
module tb_ps2_key_sequencer;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  key_code;
  logic        verify;
  logic [10:0] held_mask;
  logic        make_pulse;
  logic        break_pulse;
  logic [7:0]  event_code;
  logic        event_ext;
  logic        err_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_key_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_code(key_code), .verify(verify), .held_mask(held_mask),
    .make_pulse(make_pulse), .break_pulse(break_pulse),
    .event_code(event_code), .event_ext(event_ext), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  // Model: prefix flags, idle cycle count, and a full 256-entry held table
  logic [7:0] trk [11] = '{8'h44, 8'h4D, 8'h2C, 8'h34, 8'h25, 8'h2B,
                           8'h36, 8'h33, 8'h29, 8'h32, 8'h1C};
  bit         m_held [256];
  logic [7:0] m_key = 0;
  logic       m_ver = 0;
  logic [7:0] m_ec = 0;
  logic       m_ee = 0;
  logic       m_mk = 0, m_bk = 0, m_err = 0;
  bit         m_ext_p = 0, m_brk_p = 0;
  int         m_idle = 0;

  function automatic logic [10:0] m_mask();
    logic [10:0] m;
    for (int i = 0; i < 11; i++) m[i] = m_held[trk[i]];
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_held[i] = 0;
    m_key = 0; m_ver = 0; m_ec = 0; m_ee = 0;
    m_mk = 0; m_bk = 0; m_err = 0;
    m_ext_p = 0; m_brk_p = 0; m_idle = 0;
  endtask

  task automatic model_event(input logic [7:0] b, input bit ext, input bit brk);
    m_ec = b; m_ee = ext;
    if (brk) m_bk = 1; else m_mk = 1;
    if (!ext) begin
      if (!brk) begin
        m_key = b; m_ver = 1; m_held[b] = 1;
      end else begin
        m_held[b] = 0;
        if (b == m_key) m_ver = 0;
      end
    end
  endtask

  task automatic model_step();
    logic [7:0] b;
    m_mk = 0; m_bk = 0; m_err = 0;
    if (rx_valid) begin
      b = rx_data;
      m_idle = 0;
      if (b == 8'hE0) begin
        if (m_ext_p || m_brk_p) m_err = 1;
        m_ext_p = 1; m_brk_p = 0;
      end else if (b == 8'hF0) begin
        if (m_brk_p) begin m_err = 1; m_ext_p = 0; end
        m_brk_p = 1;
      end else if (!m_ext_p && !m_brk_p &&
                   (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
        m_idle = 0;
      end else begin
        model_event(b, m_ext_p, m_brk_p);
        m_ext_p = 0; m_brk_p = 0;
      end
    end else if (m_ext_p || m_brk_p) begin
      m_idle++;
      if (m_idle == T) begin
        m_ext_p = 0; m_brk_p = 0; m_err = 1; m_idle = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_key_code", key_code, m_key);
      chk("cyc_verify", verify, m_ver);
      chk("cyc_held_mask", held_mask, m_mask());
      chk("cyc_make", make_pulse, m_mk);
      chk("cyc_break", break_pulse, m_bk);
      chk("cyc_event_code", event_code, m_ec);
      chk("cyc_event_ext", event_ext, m_ee);
      chk("cyc_err", err_pulse, m_err);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  logic [7:0] b2b [18] = '{8'h33, 8'hE0, 8'h14, 8'hF0, 8'h33, 8'hE0, 8'hF0, 8'h14, 8'h2B,
                           8'h2B, 8'hF0, 8'hE0, 8'h2B, 8'hE0, 8'hE0, 8'h75, 8'hF0, 8'h2B};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_verify", verify, 1'b0);
    chk("rst_held_mask", held_mask, 11'h000);
    chk("rst_pulses", {make_pulse, break_pulse, err_pulse}, 3'b000);
    chk("rst_event", {event_ext, event_code}, 9'h000);
    rst_n = 1'b1;
    @(negedge clk);

    send(8'h1C);
    chk("mk1c_pulse", make_pulse, 1'b1);
    chk("mk1c_key", key_code, 8'h1C);
    chk("mk1c_verify", verify, 1'b1);
    chk("mk1c_mask", held_mask, 11'h400);
    send(8'hF0);
    chk("f0_no_pulse", {make_pulse, break_pulse}, 2'b00);
    send(8'h1C);
    chk("bk1c_pulse", break_pulse, 1'b1);
    chk("bk1c_verify", verify, 1'b0);
    chk("bk1c_mask", held_mask, 11'h000);
    chk("bk1c_key", key_code, 8'h1C);

    send(8'h25);
    send(8'h36);
    chk("two_mask", held_mask, 11'h050);
    send(8'hF0);
    chk("two_mid_verify", verify, 1'b1);
    send(8'h25);
    chk("two_after_mask", held_mask, 11'h040);
    chk("two_after_key", key_code, 8'h36);
    chk("two_after_verify", verify, 1'b1);

    send(8'hE0);
    send(8'h75);
    chk("ext_make", {make_pulse, event_ext, event_code}, {1'b1, 1'b1, 8'h75});
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext_break", {break_pulse, event_ext, event_code}, {1'b1, 1'b1, 8'h75});
    chk("ext_untouched", {key_code, verify, held_mask}, {8'h36, 1'b1, 11'h040});

    send(8'hF0);
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      chk("timeout_err", err_pulse, (k == T));
    end
    send(8'h29);
    chk("post_to_make", {make_pulse, event_ext, key_code}, {1'b1, 1'b0, 8'h29});
    chk("post_to_mask", held_mask, 11'h140);

    send(8'hF0);
    repeat (T - 1) @(negedge clk);
    send(8'h1C);
    chk("byte_wins", {break_pulse, err_pulse, event_code}, {1'b1, 1'b0, 8'h1C});

    send(8'hF0);
    send(8'hF0);
    chk("ff_err", err_pulse, 1'b1);
    send(8'h29);
    chk("ff_break", {break_pulse, event_code, verify}, {1'b1, 8'h29, 1'b0});
    chk("ff_mask", held_mask, 11'h040);

    send(8'hFA);
    chk("fa_quiet", {make_pulse, break_pulse, err_pulse}, 3'b000);
    send(8'hAA);
    chk("aa_quiet", {make_pulse, break_pulse, err_pulse}, 3'b000);

    for (int i = 0; i < 18; i++) send(b2b[i]);
    repeat (3) @(negedge clk);

    send(8'h44);
    send(8'hE0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {key_code, verify, held_mask, event_code, event_ext},
        {8'h00, 1'b0, 11'h000, 8'h00, 1'b0});
    chk("mid_rst_pulses", {make_pulse, break_pulse, err_pulse}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h44);
    chk("post_rst_make", {make_pulse, event_ext, event_code, key_code},
        {1'b1, 1'b0, 8'h44, 8'h44});
    chk("post_rst_mask", held_mask, 11'h001);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
